// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a small programmable table of (pitch, duration)
// entries on a prescaled tick and drives the note-to-phase-increment stage.
// note_pitch carries signed semitone offsets from A4; 0x80 means REST.
// tx_enable gates the DDS modulator for the whole duration of playback.
//
// Handshake: there is no valid/ready pair here. start is level-sampled in IDLE
// only, stop is level-sampled in any non-IDLE state and always wins, and done
// is a single-cycle pulse with no acknowledge.
module melody_sequencer #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int DUR_W     = 8,
   parameter int TICK_DIV  = 1000,
   parameter int GAP_TICKS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W:0]   seq_len,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_pitch,
   input  logic [DUR_W-1:0]  wr_dur,
   output logic [7:0]        note_pitch,
   output logic              tx_enable,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_index,
   output logic [1:0]        dbg_state
);

   localparam int                PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]     TICK_MAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0]     P_ONE    = PW'(1);
   localparam logic [DUR_W-1:0]  D_ONE    = DUR_W'(1);
   localparam logic [DUR_W-1:0]  GAP_LOAD = DUR_W'(GAP_TICKS);
   localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
   localparam logic [ADDR_W:0]   L_ONE    = (ADDR_W + 1)'(1);
   localparam logic [7:0]        REST     = 8'h80;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_NOTE, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [7:0]        pitch_q, pitch_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [DUR_W-1:0]  dur_q, dur_d;

   logic [7:0]        mem_pitch_q [DEPTH];
   logic [DUR_W-1:0]  mem_dur_q   [DEPTH];

   logic              tick;
   logic              last;
   logic              adv;
   logic [DUR_W-1:0]  fetch_dur;

   assign tick      = (presc_q == TICK_MAX);
   assign last      = ({1'b0, idx_q} == (len_q - L_ONE));
   assign fetch_dur = (mem_dur_q[idx_q] == '0) ? D_ONE : mem_dur_q[idx_q];

   // Note table: writable in any state; a same-cycle FETCH sees the old entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pitch_q[i] <= REST;
            mem_dur_q[i]   <= D_ONE;
         end
      end else if (wr_en) begin
         mem_pitch_q[wr_addr] <= wr_pitch;
         mem_dur_q[wr_addr]   <= wr_dur;
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pitch_q <= REST;
         tx_q    <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         len_q   <= '0;
         presc_q <= '0;
         dur_q   <= '0;
      end else begin
         state_q <= state_d;
         pitch_q <= pitch_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         presc_q <= presc_d;
         dur_q   <= dur_d;
      end
   end

   // Next-state logic: per-state stepping, then the shared advance, then stop.
   always_comb begin
      state_d = state_q;
      pitch_d = pitch_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      idx_d   = idx_q;
      len_d   = len_q;
      presc_d = presc_q;
      dur_d   = dur_q;
      adv     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (seq_len != '0) begin
                  len_d   = seq_len;
                  idx_d   = '0;
                  tx_d    = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_FETCH: begin
            pitch_d = mem_pitch_q[idx_q];
            dur_d   = fetch_dur;
            presc_d = '0;
            state_d = S_NOTE;
         end
         S_NOTE: begin
            presc_d = tick ? '0 : presc_q + P_ONE;
            if (tick) begin
               dur_d = dur_q - D_ONE;
               if (dur_q == D_ONE) begin
                  if (GAP_TICKS > 0) begin
                     state_d = S_GAP;
                     pitch_d = REST;
                     presc_d = '0;
                     dur_d   = GAP_LOAD;
                  end else begin
                     adv = 1'b1;
                  end
               end
            end
         end
         S_GAP: begin
            presc_d = tick ? '0 : presc_q + P_ONE;
            if (tick) begin
               dur_d = dur_q - D_ONE;
               if (dur_q == D_ONE) begin
                  adv = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         if (!last) begin
            idx_d   = idx_q + A_ONE;
            state_d = S_FETCH;
         end else if (loop_en) begin
            idx_d   = '0;
            state_d = S_FETCH;
         end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pitch_d = REST;
            tx_d    = 1'b0;
         end
      end

      if (stop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         pitch_d = REST;
         tx_d    = 1'b0;
         done_d  = 1'b0;
      end
   end

   assign note_pitch = pitch_q;
   assign tx_enable  = tx_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign cur_index  = idx_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=4. Instance a uses one
// gap tick between notes, instance b is the legato build. Both share inputs.
module tb_melody_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       loop_en;
   logic [4:0] seq_len;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_pitch;
   logic [7:0] wr_dur;

   logic [7:0] pitch_a, pitch_b;
   logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;
   logic [3:0] idx_a, idx_b;
   logic [1:0] st_a, st_b;

   logic [14:0] obs_a, obs_b;
   assign obs_a = {done_a, tx_a, busy_a, idx_a, pitch_a};
   assign obs_b = {done_b, tx_b, busy_b, idx_b, pitch_b};

   int n_checks = 0;
   int n_errors = 0;

   melody_sequencer #(.DEPTH(16), .ADDR_W(4), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch),
      .wr_dur(wr_dur), .note_pitch(pitch_a), .tx_enable(tx_a), .busy(busy_a),
      .done(done_a), .cur_index(idx_a), .dbg_state(st_a)
   );

   melody_sequencer #(.DEPTH(16), .ADDR_W(4), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(0)) dut_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch),
      .wr_dur(wr_dur), .note_pitch(pitch_b), .tx_enable(tx_b), .busy(busy_b),
      .done(done_b), .cur_index(idx_b), .dbg_state(st_b)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input logic [3:0] a, input logic [7:0] p, input logic [7:0] d);
      wr_en    = 1'b1;
      wr_addr  = a;
      wr_pitch = p;
      wr_dur   = d;
      step();
      wr_en    = 1'b0;
   endtask

   // n cycles of playback: done=0, tx=1, busy=1, given index and pitch.
   task automatic run(input string tag, input bit sel, input logic [7:0] p,
                      input logic [3:0] idx, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, {17'd0, (sel ? obs_b : obs_a)}, {17'd0, 3'b011, idx, p});
         step();
      end
   endtask

   // Idle: busy=0, tx=0, pitch=REST, done as given.
   task automatic check_idle(input string tag, input bit sel, input logic done_exp);
      logic [14:0] o;
      o = sel ? obs_b : obs_a;
      check(tag, {21'd0, o[14:12], o[7:0]}, {21'd0, done_exp, 2'b00, 8'h80});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; seq_len = '0;
      wr_en = 1'b0; wr_addr = '0; wr_pitch = '0; wr_dur = '0;
      step();
      step();
      // Reset state
      check("rst_outputs", {17'd0, obs_a}, {17'd0, 3'b000, 4'd0, 8'h80});
      check("rst_state", {30'd0, st_a}, 32'd0);
      rst = 1'b0;
      step();

      // 1: one-shot, three entries
      write_entry(4'd0, 8'h02, 8'd3);
      write_entry(4'd1, 8'hFB, 8'd2);
      write_entry(4'd2, 8'h80, 8'd1);
      seq_len = 5'd3; loop_en = 1'b0;
      pulse_start();
      run("t1_f0", 0, 8'h80, 4'd0, 1);
      run("t1_n0", 0, 8'h02, 4'd0, 12);
      run("t1_g0", 0, 8'h80, 4'd0, 4);
      run("t1_f1", 0, 8'h80, 4'd1, 1);
      run("t1_n1", 0, 8'hFB, 4'd1, 8);
      run("t1_g1", 0, 8'h80, 4'd1, 4);
      run("t1_f2", 0, 8'h80, 4'd2, 1);
      run("t1_n2", 0, 8'h80, 4'd2, 4);
      run("t1_g2", 0, 8'h80, 4'd2, 4);
      check_idle("t1_done", 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle("t1_after", 0, 1'b0);
      end

      // 2: loop play wraps to entry 0, never pulses done
      loop_en = 1'b1;
      pulse_start();
      run("t2_f0", 0, 8'h80, 4'd0, 1);
      run("t2_n0", 0, 8'h02, 4'd0, 12);
      run("t2_g0", 0, 8'h80, 4'd0, 4);
      run("t2_f1", 0, 8'h80, 4'd1, 1);
      run("t2_n1", 0, 8'hFB, 4'd1, 8);
      run("t2_g1", 0, 8'h80, 4'd1, 4);
      run("t2_f2", 0, 8'h80, 4'd2, 1);
      run("t2_n2", 0, 8'h80, 4'd2, 4);
      run("t2_g2", 0, 8'h80, 4'd2, 4);
      run("t2_wrap_f0", 0, 8'h80, 4'd0, 1);
      run("t2_wrap_n0", 0, 8'h02, 4'd0, 4);
      stop = 1'b1;
      step();
      stop = 1'b0;
      loop_en = 1'b0;
      check_idle("t2_stop", 0, 1'b0);

      // 3: stop mid-note, start while busy ignored, stop beats start
      pulse_start();
      run("t3_f0", 0, 8'h80, 4'd0, 1);
      start = 1'b1;
      run("t3_n0_busy_start", 0, 8'h02, 4'd0, 2);
      start = 1'b0;
      run("t3_n0", 0, 8'h02, 4'd0, 10);
      run("t3_g0", 0, 8'h80, 4'd0, 4);
      run("t3_f1", 0, 8'h80, 4'd1, 1);
      run("t3_n1", 0, 8'hFB, 4'd1, 3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_idle("t3_stop", 0, 1'b0);
      step();
      check_idle("t3_stop_hold", 0, 1'b0);
      pulse_start();
      run("t3b_f0", 0, 8'h80, 4'd0, 1);
      run("t3b_n0", 0, 8'h02, 4'd0, 3);
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check_idle("t3_stop_wins", 0, 1'b0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_idle("t3_stop_in_idle", 0, 1'b0);

      // 4: dur=0 plays one tick; seq_len=0 only pulses done
      write_entry(4'd0, 8'h07, 8'd0);
      seq_len = 5'd1;
      pulse_start();
      run("t4_f0", 0, 8'h80, 4'd0, 1);
      run("t4_n0", 0, 8'h07, 4'd0, 4);
      run("t4_g0", 0, 8'h80, 4'd0, 4);
      check_idle("t4_done", 0, 1'b1);
      step();
      seq_len = 5'd0;
      pulse_start();
      check_idle("t4_len0_done", 0, 1'b1);
      step();
      check_idle("t4_len0_after", 0, 1'b0);

      // 5: legato build, no REST between notes
      write_entry(4'd0, 8'h01, 8'd1);
      write_entry(4'd1, 8'h03, 8'd1);
      seq_len = 5'd2;
      pulse_start();
      run("t5_f0", 1, 8'h80, 4'd0, 1);
      run("t5_n0", 1, 8'h01, 4'd0, 4);
      run("t5_f1", 1, 8'h01, 4'd1, 1);
      run("t5_n1", 1, 8'h03, 4'd1, 4);
      check_idle("t5_done", 1, 1'b1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_idle("t5_a_stopped", 0, 1'b0);

      // 6: table rewrite during play, seq_len change ignored, async reset
      write_entry(4'd0, 8'h02, 8'd3);
      write_entry(4'd1, 8'hFB, 8'd2);
      seq_len = 5'd2;
      pulse_start();
      seq_len = 5'd1;
      run("t6_f0", 0, 8'h80, 4'd0, 1);
      wr_en = 1'b1; wr_addr = 4'd1; wr_pitch = 8'h09; wr_dur = 8'd1;
      run("t6_n0", 0, 8'h02, 4'd0, 1);
      wr_en = 1'b0;
      run("t6_n0", 0, 8'h02, 4'd0, 11);
      run("t6_g0", 0, 8'h80, 4'd0, 4);
      run("t6_f1", 0, 8'h80, 4'd1, 1);
      run("t6_n1_new", 0, 8'h09, 4'd1, 4);
      run("t6_g1", 0, 8'h80, 4'd1, 4);
      check_idle("t6_done", 0, 1'b1);
      seq_len = 5'd2;
      pulse_start();
      run("t6r_f0", 0, 8'h80, 4'd0, 1);
      run("t6r_n0", 0, 8'h02, 4'd0, 5);
      #2 rst = 1'b1;
      #1;
      check("t6_async_rst", {17'd0, obs_a}, {17'd0, 3'b000, 4'd0, 8'h80});
      check("t6_async_state", {30'd0, st_a}, 32'd0);
      #2 rst = 1'b0;
      step();
      seq_len = 5'd1;
      pulse_start();
      run("t6_tbl_f0", 0, 8'h80, 4'd0, 1);
      run("t6_tbl_n0", 0, 8'h80, 4'd0, 4);
      run("t6_tbl_g0", 0, 8'h80, 4'd0, 4);
      check_idle("t6_tbl_done", 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
